dashcam_dma_writer: RTL
=======================

Name: dashcam_dma_writer

Overview:
Stream-to-memory DMA write engine for the dashcam pipeline, sitting directly downstream of the CSR register block. It consumes the programmed ctrl/start, DMA base and DMA length. It buffers 32-bit camera words in a small FIFO and writes them to memory as single Wishbone classic write cycles. It produces the 32-bit DMA status word and the done/error pulses that the CSR and IRQ logic read back.

Parameters:
FIFO_DEPTH, 8, input FIFO depth in 32-bit words; power of two, minimum 2
CNT_W, 24, width of the word counters and of the status count field; maximum 24
ACK_TIMEOUT, 255, cycles to wait for ack/err before a timeout error (used only with DASHCAM_DMA_TIMEOUT_EN)

Ports:
clk  in  1  system clock, all logic on the rising edge
rst  in  1  synchronous active-high reset
start_i  in  1  one-cycle start strobe (ctrl_we & ctrl[0])
abort_i  in  1  one-cycle abort strobe (ctrl_we & ctrl[1])
base_i  in  32  byte base address (dma_base)
len_i  in  32  transfer length in bytes (dma_len)
s_data_i  in  32  camera stream data
s_valid_i  in  1  stream word valid
s_ready_o  out  1  stream word accepted when s_valid_i & s_ready_o
wbm_adr_o  out  32  Wishbone master address
wbm_dat_o  out  32  Wishbone master write data
wbm_sel_o  out  4  byte selects, constant 4'hF
wbm_we_o  out  1  write enable, equals wbm_cyc_o
wbm_stb_o  out  1  strobe
wbm_cyc_o  out  1  cycle
wbm_ack_i  in  1  slave ack
wbm_err_i  in  1  slave error
dma_status_o  out  32  status word to CSR (dma_status_in)
done_pulse_o  out  1  one-cycle transfer-complete pulse
err_pulse_o  out  1  one-cycle error pulse

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - State becomes IDLE. FIFO is flushed. All counters clear.
  - wbm_cyc_o, wbm_stb_o, s_ready_o, done_pulse_o and err_pulse_o are 0. wbm_adr_o = 0. dma_status_o = 0.
  - A reset mid-transfer drops cyc/stb at that edge with no completion pulse.
- Start (IDLE only; a start while busy is ignored):
  - Latch addr = {base_i[31:2],2'b00}.
  - Latch words = len_i[CNT_W+1:2]; len_i[1:0] is ignored.
  - Clear the sticky status bits. Go to RUN.
  - If words == 0, go to DONE instead.
- States:
  - IDLE
  - RUN: wait for FIFO data.
  - WRITE: cyc=stb=1.
  - DONE: 1 cycle.
  - FAIL: 1 cycle.
- Stream acceptance:
  - s_ready_o = (state is RUN or WRITE) & !fifo_full & (accepted < words).
  - Words beyond len are never accepted.
  - A push and a pop in the same cycle are legal and leave the occupancy unchanged.
- Write timing:
  - RUN -> WRITE at the edge after the FIFO becomes non-empty.
  - A word accepted at edge k gives stb high from edge k+1 when the FIFO was previously empty.
  - wbm_dat_o = FIFO head. wbm_adr_o = current addr.
  - Both are held stable while stb=1 and ack=0.
- On ack in WRITE:
  - Pop the FIFO, addr += 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), written += 1.
  - If written+1 == words, go to DONE.
  - Else if the FIFO holds another word, stay in WRITE (back-to-back beats, stb stays high).
  - Else go to RUN (stb low).
- On err in WRITE:
  - Go to FAIL and set err_sticky.
  - If ack and err are high in the same cycle, err wins: no pop, no count.
- DONE: done_pulse_o=1 for one cycle, set done_sticky, go to IDLE.
- FAIL: err_pulse_o=1 for one cycle, flush the FIFO, go to IDLE.
- Abort:
  - In RUN: take effect next edge. Flush the FIFO, set abort_sticky, go to IDLE, no pulse.
  - In WRITE: record it and finish the current beat (ack or err), then abort as above. err still takes the FAIL path.
  - Abort and start in the same IDLE cycle: abort wins, no start.
- dma_status_o layout:
  - [31] busy (state != IDLE)
  - [30] done_sticky
  - [29] err_sticky
  - [28] abort_sticky
  - [27] timeout_sticky
  - [26:24] 0
  - [CNT_W-1:0] written
  - The sticky bits clear only on an accepted start or on reset.

Optional Feature:
DASHCAM_DMA_TIMEOUT_EN:
- Defined:
  - A counter runs while in WRITE. It reloads on every ack and on each entry to WRITE.
  - After ACK_TIMEOUT cycles with no ack/err: drop cyc/stb, set timeout_sticky and err_sticky, go to FAIL.
- Undefined:
  - No counter is built, bit [27] reads 0, and WRITE waits indefinitely.

Test Plan:
- Basic transfer: base=0x1000, len=16, start, feed 4 words A0..A3 back to back, ack each next cycle -> writes to 0x1000/4/8/C with data A0..A3; one done pulse; status=0x40000004.
- Unaligned inputs and zero length:
  - base=0x1003, len=0x13 -> 4 writes starting 0x1000.
  - len=3 -> no Wishbone cycle; done pulse 2 cycles after start.
- Backpressure and FIFO full: FIFO_DEPTH=8, len=64, hold ack low for 20 cycles -> s_ready_o falls after 8 accepted words; nothing lost; 16 ordered writes complete.
- Error: wbm_err_i together with ack on the 3rd beat -> err pulse; status bits 29=1, 31=0, count=2; FIFO empty; next start clears bit 29.
- Abort mid-beat: abort on a cycle where stb=1 and ack=0, ack 3 cycles later -> that beat is counted, then IDLE; abort_sticky=1; no done or err pulse; a start+abort in the same cycle does nothing.
- Wrap and timeout:
  - base=0xFFFFFFF8, len=16 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
  - With DASHCAM_DMA_TIMEOUT_EN and ACK_TIMEOUT=10, never ack -> stb drops after 10 cycles; status bits 27 and 29 set.

Source files
------------

// File: rtl/dashcam_dma_writer.sv
// Stream-to-memory DMA writer: buffers 32-bit camera words and writes them as single Wishbone classic beats.
// Latency: a word accepted at edge k raises stb from edge k+1 when the FIFO was empty; one beat per ack.
// Backpressure: s_ready_o drops when the FIFO is full, past the programmed length, or outside RUN/WRITE.
// Optional ack/err watchdog built only when DASHCAM_DMA_TIMEOUT_EN is defined.

// Small synchronous FIFO with flush; head word is visible on rd_dat while not empty.
// Latency: a pushed word is readable the cycle after the push edge.
// Backpressure: writes are dropped while full, reads ignored while empty; flush wins over push/pop.
module dashcam_dma_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_vld,
    input  logic [W-1:0]  wr_dat,
    input  logic          rd_rdy,
    output logic [W-1:0]  rd_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_ok  = wr_vld && !full;
    assign rd_ok  = rd_rdy && !empty;
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

module dashcam_dma_writer #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 24,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] base_i,
    input  logic [31:0] len_i,
    input  logic [31:0] s_data_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic [31:0] dma_status_o,
    output logic        done_pulse_o,
    output logic        err_pulse_o
);
    localparam int FAW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WRITE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [31:0]      addr;
    logic [CNT_W-1:0] words;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] written;
    logic [CNT_W-1:0] len_words;
    logic             done_sticky;
    logic             err_sticky;
    logic             abort_sticky;
    logic             timeout_sticky;
    logic             abort_pend;
    logic             do_start;
    logic             do_pop;
    logic             do_abort;
    logic             do_err;
    logic             do_tmo;
    logic             fifo_flush;
    logic             fifo_full;
    logic             fifo_empty;
    logic [FAW:0]     fifo_count;
    logic [31:0]      fifo_head;
    logic             s_hs;
    logic [23:0]      cnt_field;
    logic             unused_bits;

    assign len_words   = len_i[CNT_W+1:2];
    assign unused_bits = ^{base_i[1:0], len_i[1:0], len_i[31:CNT_W+2]};

    assign s_ready_o  = ((state == S_RUN) || (state == S_WRITE)) && !fifo_full && (accepted < words);
    assign s_hs       = s_valid_i && s_ready_o;
    assign fifo_flush = do_abort || (state == S_FAIL);

    dashcam_dma_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (fifo_flush),
        .wr_vld (s_hs),
        .wr_dat (s_data_i),
        .rd_rdy (do_pop),
        .rd_dat (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

`ifdef DASHCAM_DMA_TIMEOUT_EN
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_cnt;

    // Restarts from zero on every entry to WRITE and after every ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state == S_WRITE && !wbm_ack_i && !wbm_err_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || do_start) begin
            timeout_sticky <= 1'b0;
        end else if (do_tmo) begin
            timeout_sticky <= 1'b1;
        end
    end
`else
    assign timeout_sticky = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_pop     = 1'b0;
        do_abort   = 1'b0;
        do_err     = 1'b0;
        do_tmo     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    do_start   = 1'b1;
                    state_next = (len_words == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    do_abort   = 1'b1;
                    state_next = S_IDLE;
                end else if (!fifo_empty) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wbm_err_i) begin
                    do_err     = 1'b1;
                    state_next = S_FAIL;
                end else if (wbm_ack_i) begin
                    do_pop = 1'b1;
                    // A pending abort closes the transfer even if this was the final beat.
                    if (abort_pend || abort_i) begin
                        do_abort   = 1'b1;
                        state_next = S_IDLE;
                    end else if (written + 1'b1 == words) begin
                        state_next = S_DONE;
                    end else if (fifo_count > (FAW+1)'(1)) begin
                        state_next = S_WRITE;
                    end else begin
                        state_next = S_RUN;
                    end
                end
`ifdef DASHCAM_DMA_TIMEOUT_EN
                else if (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1)) begin
                    do_tmo     = 1'b1;
                    do_err     = 1'b1;
                    state_next = S_FAIL;
                end
`endif
            end
            S_DONE:  state_next = S_IDLE;
            S_FAIL:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            abort_pend <= 1'b0;
        end else if (state == S_WRITE && state_next == S_WRITE) begin
            abort_pend <= abort_pend || abort_i;
        end else begin
            abort_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr         <= '0;
            words        <= '0;
            accepted     <= '0;
            written      <= '0;
            done_sticky  <= 1'b0;
            err_sticky   <= 1'b0;
            abort_sticky <= 1'b0;
        end else if (do_start) begin
            addr         <= {base_i[31:2], 2'b00};
            words        <= len_words;
            accepted     <= '0;
            written      <= '0;
            done_sticky  <= 1'b0;
            err_sticky   <= 1'b0;
            abort_sticky <= 1'b0;
        end else begin
            if (s_hs) begin
                accepted <= accepted + 1'b1;
            end
            if (do_pop) begin
                addr    <= addr + 32'd4;
                written <= written + 1'b1;
            end
            if (do_err) begin
                err_sticky <= 1'b1;
            end
            if (do_abort) begin
                abort_sticky <= 1'b1;
            end
            if (state == S_DONE) begin
                done_sticky <= 1'b1;
            end
        end
    end

    assign wbm_cyc_o    = (state == S_WRITE);
    assign wbm_stb_o    = wbm_cyc_o;
    assign wbm_we_o     = wbm_cyc_o;
    assign wbm_sel_o    = 4'hF;
    assign wbm_adr_o    = addr;
    assign wbm_dat_o    = fifo_head;
    assign done_pulse_o = (state == S_DONE);
    assign err_pulse_o  = (state == S_FAIL);

    assign cnt_field    = 24'(written);
    assign dma_status_o = {(state != S_IDLE), done_sticky, err_sticky, abort_sticky,
                           timeout_sticky, 3'b000, cnt_field};
endmodule
